// File: rtl/accum_periph_arbiter_if.sv
// accum_periph_arbiter_if: requester and peripheral signals of the
// accumulator arbiter, bundled with arbiter/environment modports.
interface accum_periph_arbiter_if;
  logic        req0_valid;
  logic        req0_we;
  logic [1:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic        req0_ready;
  logic        req1_valid;
  logic        req1_we;
  logic [1:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic        req1_ready;
  logic        resp0_valid;
  logic [31:0] resp0_rdata;
  logic        resp0_err;
  logic        resp1_valid;
  logic [31:0] resp1_rdata;
  logic        resp1_err;
  logic        p_ce;
  logic        p_we;
  logic [1:0]  p_addr;
  logic [31:0] p_wdata;
  logic        p_stall;
  logic [31:0] p_rdata;
  logic        p_valid;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  p_rdata, p_valid,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_rdata, resp0_err,
    output resp1_valid, resp1_rdata, resp1_err,
    output p_ce, p_we, p_addr, p_wdata, p_stall
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output p_rdata, p_valid,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_rdata, resp0_err,
    input  resp1_valid, resp1_rdata, resp1_err,
    input  p_ce, p_we, p_addr, p_wdata, p_stall
  );
endinterface

// File: rtl/accum_periph_arbiter.sv
// accum_periph_arbiter: round-robin arbiter that serialises two command
// ports onto the accumulator peripheral and returns one response each.
module accum_periph_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  accum_periph_arbiter_if.slave bus
);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  logic [0:0]  state_q, state_d;
  logic        last_gnt_q;
  logic        owner_q;
  logic        we_q;
  logic [1:0]  addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_inc;
  logic        r0_valid_q, r1_valid_q;
  logic        r0_err_q, r1_err_q;
  logic [31:0] r0_rdata_q, r1_rdata_q;

  logic        idle, active;
  logic        gnt0, gnt1;
  logic        commit, abort;
  logic        sel_we;
  logic [1:0]  sel_addr;
  logic [31:0] sel_wdata;

  assign idle    = (state_q == S_IDLE) && !reset;
  assign active  = (state_q == S_ACTIVE) && !reset;
  assign cnt_inc = cnt_q + 8'd1;
  assign commit  = active && bus.p_valid;
  assign abort   = active && !bus.p_valid && (cnt_inc == TO_LAST);

  // Arbitration: on a tie, grant the port that did not win last time
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (idle) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last_gnt_q;
        gnt1 = !last_gnt_q;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  // Payload of the winning port, latched on the handshake edge
  always_comb begin
    sel_we    = gnt1 ? bus.req1_we    : bus.req0_we;
    sel_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
    sel_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
  end

  // Next state: enter ACTIVE on a grant, leave on commit or abort
  always_comb begin
    state_d = state_q;
    if (idle && (gnt0 || gnt1)) state_d = S_ACTIVE;
    if (commit || abort)        state_d = S_IDLE;
  end

  // Command latch, timeout counter and registered responses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 2'b00;
      wdata_q    <= '0;
      cnt_q      <= '0;
      r0_valid_q <= 1'b0;
      r1_valid_q <= 1'b0;
      r0_err_q   <= 1'b0;
      r1_err_q   <= 1'b0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      r0_valid_q <= 1'b0;
      r1_valid_q <= 1'b0;
      if (gnt0 || gnt1) begin
        owner_q    <= gnt1;
        last_gnt_q <= gnt1;
        we_q       <= sel_we;
        addr_q     <= sel_addr;
        wdata_q    <= sel_wdata;
        cnt_q      <= '0;
      end
      if (active && !bus.p_valid && !abort) cnt_q <= cnt_inc;
      if (commit || abort) begin
        if (owner_q) begin
          r1_valid_q <= 1'b1;
          r1_rdata_q <= abort ? 32'd0 : bus.p_rdata;
          r1_err_q   <= abort;
        end else begin
          r0_valid_q <= 1'b1;
          r0_rdata_q <= abort ? 32'd0 : bus.p_rdata;
          r0_err_q   <= abort;
        end
      end
    end
  end

  assign bus.req0_ready  = gnt0;
  assign bus.req1_ready  = gnt1;
  assign bus.resp0_valid = r0_valid_q;
  assign bus.resp0_rdata = r0_rdata_q;
  assign bus.resp0_err   = r0_err_q;
  assign bus.resp1_valid = r1_valid_q;
  assign bus.resp1_rdata = r1_rdata_q;
  assign bus.resp1_err   = r1_err_q;
  assign bus.p_ce        = active;
  assign bus.p_we        = active && we_q;
  assign bus.p_addr      = active ? addr_q : 2'b00;
  assign bus.p_wdata     = active ? wdata_q : 32'd0;
  assign bus.p_stall     = !(active && bus.p_valid);
endmodule

// File: tb/tb_accum_periph_arbiter.sv
// tb_accum_periph_arbiter: directed bench with a behavioural
// accumulator/counter peripheral behind the arbiter.
module tb_accum_periph_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  accum_periph_arbiter_if bus ();

  accum_periph_arbiter #(.TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        per_rst;
  logic        auto_pv;
  logic        man_pv;
  logic [1:0]  ph;
  logic [31:0] m_acc;
  logic [31:0] m_cnt;
  int          commits;

  always @(posedge clk) begin
    ph <= per_rst ? 2'd0 : ph + 2'd1;
    if (per_rst) begin
      m_acc   <= 32'd0;
      m_cnt   <= 32'd0;
      commits <= 0;
    end else if (bus.p_ce && bus.p_valid) begin
      commits <= commits + 1;
      if (bus.p_we) begin
        case (bus.p_addr)
          2'b00: begin m_acc <= 32'd0; m_cnt <= 32'd0; end
          2'b01: begin m_acc <= m_acc + bus.p_wdata; m_cnt <= m_cnt + 32'd1; end
          default: ;
        endcase
      end
    end
  end

  assign bus.p_valid = auto_pv ? (ph == 2'd3) : man_pv;
  assign bus.p_rdata = (bus.p_addr == 2'b10) ? m_acc :
                       (bus.p_addr == 2'b11) ? m_cnt : 32'd0;

  int          gseq[8];
  int          ng;
  logic [31:0] last_rd[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [1:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_we = we;
      bus.req0_addr = a;  bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_we = we;
      bus.req1_addr = a;  bus.req1_wdata = d;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic rsp_v(input int p);
    return (p == 0) ? bus.resp0_valid : bus.resp1_valid;
  endfunction

  function automatic logic [31:0] rsp_d(input int p);
    return (p == 0) ? bus.resp0_rdata : bus.resp1_rdata;
  endfunction

  function automatic logic rsp_e(input int p);
    return (p == 0) ? bus.resp0_err : bus.resp1_err;
  endfunction

  task automatic run_one(input string tag, input int p, input logic we,
                         input logic [1:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int lo, input int hi);
    int acc_c;
    int lat;
    bit got;
    set_req(p, 1'b1, we, a, d);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rdy(p)) begin got = 1; break; end
      tick();
    end
    chkb({tag, "_accept"}, got, 1'b1);
    acc_c = cyc;
    if (got) tick();
    set_req(p, 1'b0, we, a, d);
    if (!got) return;
    got = 0;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (rsp_v(1 - p)) chkb({tag, "_other"}, rsp_v(1 - p), 1'b0);
      if (rsp_v(p)) begin got = 1; lat = cyc - acc_c; break; end
      tick();
    end
    chkb({tag, "_resp"}, got, 1'b1);
    if (got) begin
      chkb($sformatf("%s_lat%0d", tag, lat), (lat >= lo) && (lat <= hi), 1'b1);
      chk({tag, "_rdata"}, rsp_d(p), exp_rd);
      chkb({tag, "_err"}, rsp_e(p), exp_err);
      tick();
    end
  endtask

  task automatic dual(input string tag, input int n0, input int n1,
                      input logic we0, input logic [1:0] a0, input logic [31:0] d0,
                      input logic we1, input logic [1:0] a1, input logic [31:0] d1);
    int rem[2];
    int nr;
    int pend;
    int g;
    rem[0] = n0;
    rem[1] = n1;
    ng = 0;
    nr = 0;
    pend = -1;
    set_req(0, n0 > 0, we0, a0, d0);
    set_req(1, n1 > 0, we1, a1, d1);
    for (int c = 0; c < 100; c++) begin
      #1;
      if (bus.resp0_valid) begin
        nr++;
        chk({tag, "_owner0"}, pend, 32'd0);
        last_rd[0] = bus.resp0_rdata;
      end
      if (bus.resp1_valid) begin
        nr++;
        chk({tag, "_owner1"}, pend, 32'd1);
        last_rd[1] = bus.resp1_rdata;
      end
      if (bus.req0_ready && bus.req1_ready)
        chkb({tag, "_tworeadies"}, bus.req1_ready, 1'b0);
      g = -1;
      if (bus.req0_ready) g = 0;
      else if (bus.req1_ready) g = 1;
      if (nr == n0 + n1) break;
      tick();
      if (g >= 0 && ng < 8) begin
        gseq[ng] = g;
        ng++;
        pend = g;
        rem[g]--;
        if (rem[g] == 0) begin
          if (g == 0) bus.req0_valid = 1'b0;
          else        bus.req1_valid = 1'b0;
        end
      end
    end
    chk({tag, "_nresp"}, nr, n0 + n1);
    chk({tag, "_ngrant"}, ng, n0 + n1);
  endtask

  initial begin
    int c0;
    int n;
    reset   = 1'b1;
    per_rst = 1'b1;
    auto_pv = 1'b1;
    man_pv  = 1'b0;
    set_req(0, 1'b0, 1'b0, 2'b00, 32'd0);
    set_req(1, 1'b0, 1'b0, 2'b00, 32'd0);
    repeat (2) tick();

    set_req(0, 1'b1, 1'b1, 2'b01, 32'd1);
    set_req(1, 1'b1, 1'b1, 2'b01, 32'd2);
    #1;
    chkb("rst_ready0", bus.req0_ready, 1'b0);
    chkb("rst_ready1", bus.req1_ready, 1'b0);
    chkb("rst_rvalid0", bus.resp0_valid, 1'b0);
    chkb("rst_rvalid1", bus.resp1_valid, 1'b0);
    chk("rst_rdata0", bus.resp0_rdata, 32'd0);
    chk("rst_rdata1", bus.resp1_rdata, 32'd0);
    chkb("rst_err0", bus.resp0_err, 1'b0);
    chkb("rst_err1", bus.resp1_err, 1'b0);
    chkb("rst_ce", bus.p_ce, 1'b0);
    chkb("rst_we", bus.p_we, 1'b0);
    chk("rst_addr", {30'd0, bus.p_addr}, 32'd0);
    chk("rst_wdata", bus.p_wdata, 32'd0);
    chkb("rst_stall", bus.p_stall, 1'b1);

    reset   = 1'b0;
    per_rst = 1'b0;
    dual("tie", 3, 3, 1'b1, 2'b01, 32'd1, 1'b1, 2'b01, 32'd2);
    for (int i = 0; i < 6; i++)
      chk($sformatf("tie_gnt%0d", i), gseq[i], i % 2);
    run_one("tie_acc", 0, 1'b0, 2'b10, 32'd0, 32'd9, 1'b0, 2, 5);
    run_one("tie_cnt", 0, 1'b0, 2'b11, 32'd0, 32'd6, 1'b0, 2, 5);

    run_one("sw_clr", 0, 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 2, 5);
    c0 = commits;
    run_one("sw_wr", 0, 1'b1, 2'b01, 32'd5, 32'd0, 1'b0, 2, 5);
    chk("sw_commits", commits - c0, 32'd1);
    run_one("sw_rdacc", 0, 1'b0, 2'b10, 32'd0, 32'd5, 1'b0, 2, 5);
    run_one("sw_rdcnt", 0, 1'b0, 2'b11, 32'd0, 32'd1, 1'b0, 2, 5);

    run_one("ro_clr", 0, 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 2, 5);
    run_one("ro_a3", 0, 1'b1, 2'b01, 32'd3, 32'd0, 1'b0, 2, 5);
    run_one("ro_b3", 0, 1'b1, 2'b01, 32'd3, 32'd0, 1'b0, 2, 5);
    run_one("ro_c1", 0, 1'b1, 2'b01, 32'd1, 32'd0, 1'b0, 2, 5);
    dual("ro", 1, 1, 1'b1, 2'b01, 32'd10, 1'b0, 2'b11, 32'd0);
    chk("ro_first", gseq[0], 32'd1);
    chk("ro_second", gseq[1], 32'd0);
    chk("ro_rd1", last_rd[1], 32'd3);
    run_one("ro_rdacc", 0, 1'b0, 2'b10, 32'd0, 32'd17, 1'b0, 2, 5);

    auto_pv = 1'b0;
    man_pv  = 1'b0;
    c0 = commits;
    set_req(0, 1'b1, 1'b1, 2'b01, 32'd4);
    #1;
    chkb("st_ready", bus.req0_ready, 1'b1);
    tick();
    set_req(0, 1'b0, 1'b1, 2'b01, 32'd4);
    for (int i = 0; i < 3; i++) begin
      chkb($sformatf("st_stall%0d", i), bus.p_stall, 1'b1);
      chkb($sformatf("st_ce%0d", i), bus.p_ce, 1'b1);
      chkb($sformatf("st_rv%0d", i), bus.resp0_valid, 1'b0);
      tick();
    end
    chk("st_frozen_commits", commits - c0, 32'd0);
    chk("st_frozen_acc", m_acc, 32'd17);
    man_pv = 1'b1;
    #1;
    chkb("st_open", bus.p_stall, 1'b0);
    tick();
    man_pv = 1'b0;
    chkb("st_rv", bus.resp0_valid, 1'b1);
    chkb("st_err", bus.resp0_err, 1'b0);
    chk("st_rdata", bus.resp0_rdata, 32'd0);
    chk("st_commits", commits - c0, 32'd1);
    tick();
    auto_pv = 1'b1;
    run_one("st_rdacc", 0, 1'b0, 2'b10, 32'd0, 32'd21, 1'b0, 2, 5);

    auto_pv = 1'b0;
    man_pv  = 1'b0;
    c0 = commits;
    run_one("to", 0, 1'b1, 2'b01, 32'd99, 32'd0, 1'b1, 15, 15);
    chk("to_commits", commits - c0, 32'd0);
    auto_pv = 1'b1;
    run_one("to_next", 0, 1'b0, 2'b10, 32'd0, 32'd21, 1'b0, 2, 5);

    auto_pv = 1'b0;
    man_pv  = 1'b0;
    c0 = commits;
    set_req(0, 1'b1, 1'b1, 2'b01, 32'd50);
    #1;
    chkb("mr_ready", bus.req0_ready, 1'b1);
    tick();
    set_req(0, 1'b0, 1'b1, 2'b01, 32'd50);
    reset  = 1'b1;
    man_pv = 1'b1;
    #1;
    chkb("mr_ce_a", bus.p_ce, 1'b0);
    chkb("mr_stall_a", bus.p_stall, 1'b1);
    tick();
    chkb("mr_ce_b", bus.p_ce, 1'b0);
    chkb("mr_stall_b", bus.p_stall, 1'b1);
    chkb("mr_rv", bus.resp0_valid, 1'b0);
    chk("mr_rdata", bus.resp0_rdata, 32'd0);
    chkb("mr_err", bus.resp0_err, 1'b0);
    tick();
    reset  = 1'b0;
    man_pv = 1'b0;
    #1;
    chkb("mr_ce_c", bus.p_ce, 1'b0);
    chkb("mr_stall_c", bus.p_stall, 1'b1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.resp0_valid || bus.resp1_valid) n++;
      tick();
    end
    chk("mr_noresp", n, 32'd0);
    chk("mr_commits", commits - c0, 32'd0);
    auto_pv = 1'b1;
    dual("mrt", 1, 1, 1'b0, 2'b10, 32'd0, 1'b0, 2'b11, 32'd0);
    chk("mrt_first", gseq[0], 32'd0);
    chk("mrt_rd0", last_rd[0], 32'd21);
    chk("mrt_rd1", last_rd[1], 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
